div: RTL and testbench

Sequential restoring divider that undoes the shift-add multiplier: it divides a 16-bit dividend (the multiplier's product width) by an 8-bit divisor and produces a 16-bit quotient and 8-bit remainder. It resolves one quotient bit per clock, MSB first. Start/busy handshake is identical to the multiplier's, so the two blocks share a controller. A one-cycle done pulse and a divide-by-zero flag are added.

---
 rtl/div.sv | 117 +++++++++++
 tb/tb_div.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient
// bit per clock, MSB first. Start/busy handshake matches the shift-add
// multiplier. Divide-by-zero completes in one clock with a flagged result.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_i,
    input  logic [7:0]  b_i,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        dbz
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  r;
    logic [15:0] q;
    logic [3:0]  ctr;

    logic [8:0]  t;
    logic [8:0]  diff;
    logic        ge;
    logic [7:0]  r_next;
    logic [15:0] q_next;

    // One restoring step: shift in the next dividend bit, trial-subtract
    // the divisor at 9 bits so the compare never overflows.
    always_comb begin
        t      = {r, a[ctr]};
        diff   = t - {1'b0, b};
        ge     = (t >= {1'b0, b});
        r_next = ge ? diff[7:0] : t[7:0];
        q_next = q;
        q_next[ctr] = ge;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero divisor never leaves IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && (b_i != '0)) state_next = CALC;
            CALC: if (ctr == '0)            state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    // Datapath and result registers; results change only on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            r         <= '0;
            q         <= '0;
            ctr       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_i != '0) begin
                            a   <= a_i;
                            b   <= b_i;
                            r   <= '0;
                            q   <= '0;
                            ctr <= 4'd15;
                        end else begin
                            quotient  <= '1;
                            remainder <= a_i[7:0];
                            dbz       <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r <= r_next;
                    q <= q_next;
                    if (ctr == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        dbz       <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        ctr <= ctr - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed scenarios plus randomized operands
// checked against plain integer division.
module tb_div;

    logic        clk;
    logic        rst;
    logic [15:0] a_i;
    logic [7:0]  b_i;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    int checks;
    int errors;

    div dut (
        .clk       (clk),
        .rst       (rst),
        .a_i       (a_i),
        .b_i       (b_i),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse from a negedge; returns at the negedge after E0.
    task automatic do_start(input logic [15:0] av, input logic [7:0] bv);
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; cycles = edges after E0 when done is seen.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, dbz} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
                     busy, done, quotient, remainder, dbz);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c, bc;
        do_start(16'd200, 8'd7);
        wait_done(c, bc);
        checks++;
        if (done !== 1'b1 || c != 16) begin
            errors++;
            $display("FAIL basic_latency got done=%b cycles=%0d expected done=1 cycles=16", done, c);
        end
        checks++;
        if (bc != 16) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d expected 16", bc);
        end
        checks++;
        if (quotient !== 16'd28 || remainder !== 8'd4 || dbz !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got q=%0d r=%0d dbz=%b busy=%b expected q=28 r=4 dbz=0 busy=0",
                     quotient, remainder, dbz, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b one cycle later expected 0", done);
        end
    endtask

    task automatic test_range();
        logic [15:0] av [3];
        logic [7:0]  bv [3];
        int c, bc;
        av[0] = 16'd65535; bv[0] = 8'd255;
        av[1] = 16'd100;   bv[1] = 8'd200;
        av[2] = 16'd0;     bv[2] = 8'd1;
        for (int i = 0; i < 3; i++) begin
            do_start(av[i], bv[i]);
            wait_done(c, bc);
            checks++;
            if (done !== 1'b1 || quotient !== 16'(av[i] / bv[i]) ||
                remainder !== 8'(av[i] % bv[i]) || dbz !== 1'b0) begin
                errors++;
                $display("FAIL range_%0d got done=%b q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=0",
                         i, done, quotient, remainder, dbz, av[i] / bv[i], av[i] % bv[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dbz();
        int c, bc;
        do_start(16'd1234, 8'd0);
        wait_done(c, bc);
        checks++;
        if (done !== 1'b1 || c != 0 || bc != 0) begin
            errors++;
            $display("FAIL dbz_timing got done=%b cycles=%0d busy_cycles=%0d expected 1/0/0", done, c, bc);
        end
        checks++;
        if (quotient !== 16'hFFFF || remainder !== 8'hD2 || dbz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q=%h r=%h dbz=%b expected q=ffff r=d2 dbz=1",
                     quotient, remainder, dbz);
        end
        @(negedge clk);
        do_start(16'd10, 8'd3);
        wait_done(c, bc);
        checks++;
        if (done !== 1'b1 || quotient !== 16'd3 || remainder !== 8'd1 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL dbz_recover got done=%b q=%0d r=%0d dbz=%b expected q=3 r=1 dbz=0",
                     done, quotient, remainder, dbz);
        end
        @(negedge clk);
        // Two consecutive zero-divisor starts give two adjacent done pulses.
        a_i   = 16'h0155;
        b_i   = 8'd0;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || remainder !== 8'h55) begin
            errors++;
            $display("FAIL dbz_consecutive got done=%b busy=%b r=%h expected done=1 busy=0 r=55",
                     done, busy, remainder);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int c, bc;
        do_start(16'd1000, 8'd9);
        repeat (4) @(negedge clk);
        a_i   = 16'd7;
        b_i   = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c, bc);
        checks++;
        if (done !== 1'b1 || quotient !== 16'd111 || remainder !== 8'd1 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy got done=%b q=%0d r=%0d dbz=%b expected q=111 r=1 dbz=0",
                     done, quotient, remainder, dbz);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy_idle got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int c, bc, dones;
        do_start(16'd5000, 8'd13);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, dbz} !== '0) begin
            errors++;
            $display("FAIL reset_mid_op got busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
                     busy, done, quotient, remainder, dbz);
        end
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d done/busy cycles expected 0", dones);
        end
        do_start(16'd5000, 8'd13);
        wait_done(c, bc);
        checks++;
        if (done !== 1'b1 || quotient !== 16'd384 || remainder !== 8'd8) begin
            errors++;
            $display("FAIL reset_rerun got done=%b q=%0d r=%0d expected q=384 r=8",
                     done, quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c, t1, t2;
        logic [15:0] q1;
        logic [7:0]  r1;
        t1 = -1;
        t2 = -1;
        q1 = '0;
        r1 = '0;
        a_i   = 16'd300;
        b_i   = 8'd10;
        start = 1'b1;
        @(negedge clk);
        a_i = 16'd301;
        c   = 0;
        while (t2 < 0 && c < 60) begin
            if (done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = c;
                    q1 = quotient;
                    r1 = remainder;
                end else begin
                    t2 = c;
                end
            end
            if (t1 >= 0 && c == t1 + 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1 || quotient !== 16'd30 || remainder !== 8'd0) begin
                    errors++;
                    $display("FAIL b2b_held got busy=%b q=%0d r=%0d expected busy=1 q=30 r=0",
                             busy, quotient, remainder);
                end
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        checks++;
        if (q1 !== 16'd30 || r1 !== 8'd0) begin
            errors++;
            $display("FAIL b2b_first got q=%0d r=%0d expected q=30 r=0", q1, r1);
        end
        checks++;
        if (t2 < 0 || t2 - t1 != 17 || quotient !== 16'd30 || remainder !== 8'd1) begin
            errors++;
            $display("FAIL b2b_second got t1=%0d t2=%0d q=%0d r=%0d expected spacing 17 q=30 r=1",
                     t1, t2, quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int c, bc;
        int unsigned av, bv;
        for (int i = 0; i < 1000; i++) begin
            av = $urandom_range(65535, 0);
            bv = $urandom_range(255, 1);
            do_start(16'(av), 8'(bv));
            a_i = 16'($urandom);
            b_i = 8'($urandom);
            wait_done(c, bc);
            checks++;
            if (done !== 1'b1 || int'(quotient) * bv + int'(remainder) != av ||
                int'(remainder) >= bv || dbz !== 1'b0) begin
                errors++;
                $display("FAIL random_identity %0d/%0d got done=%b q=%0d r=%0d dbz=%b",
                         av, bv, done, quotient, remainder, dbz);
            end
            checks++;
            if (int'(quotient) != av / bv || int'(remainder) != av % bv) begin
                errors++;
                $display("FAIL random_value %0d/%0d got q=%0d r=%0d expected q=%0d r=%0d",
                         av, bv, quotient, remainder, av / bv, av % bv);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_range();
        test_dbz();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
